branch_pc_ctrl: RTL and testbench

- Sequences the fetch PC and resolves conditional branches in the ID stage of the 16-bit pipelined core.
- Owns the architectural flag register {N,Z,V} and applies per-flag updates from the EX-stage ALU.
- Detects flag hazards, stalls the front end for one cycle when a branch depends on an in-flight flag write, and redirects or flushes on a taken branch.
- Freezes fetch on HALT.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/branch_pc_ctrl_cond_eval.sv | 30 +++
 rtl/branch_pc_ctrl.sv | 111 +++++++++++
 tb/tb_branch_pc_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit core front end: condition codes, flag
// bit positions and the PC sequencer state encoding.
package cpu_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_OFF_W  = 9;

   localparam logic [2:0] COND_NE  = 3'b000;
   localparam logic [2:0] COND_EQ  = 3'b001;
   localparam logic [2:0] COND_GT  = 3'b010;
   localparam logic [2:0] COND_LT  = 3'b011;
   localparam logic [2:0] COND_GE  = 3'b100;
   localparam logic [2:0] COND_LE  = 3'b101;
   localparam logic [2:0] COND_VS  = 3'b110;
   localparam logic [2:0] COND_UNC = 3'b111;

   localparam int FLAG_N = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_FLAG_WAIT = 2'd1,
      ST_HALT      = 2'd2
   } pc_state_t;

endpackage

// File: rtl/branch_pc_ctrl_cond_eval.sv
// Combinational branch condition evaluation: condition code x {N,Z,V} -> taken.
module branch_cond_eval
   import cpu_pkg::*;
(
   input  logic [2:0] cond,
   input  logic [2:0] flags,
   output logic       taken
);

   logic n, z, v;

   assign n = flags[FLAG_N];
   assign z = flags[FLAG_Z];
   assign v = flags[FLAG_V];

   always_comb begin
      taken = 1'b1;
      case (cond)
         COND_NE: taken = ~z;
         COND_EQ: taken = z;
         COND_GT: taken = ~z & ~n;
         COND_LT: taken = n;
         COND_GE: taken = z | ~n;
         COND_LE: taken = n | z;
         COND_VS: taken = v;
         default: taken = 1'b1;
      endcase
   end

endmodule

// File: rtl/branch_pc_ctrl.sv
// Fetch PC sequencer and ID-stage branch resolver with the {N,Z,V} flag register.
//   state        | meaning
//   ST_RUN       | normal fetch; branches resolve unless a flag write is in flight
//   ST_FLAG_WAIT | one-cycle bubble done; resolve the held branch on fresh flags
//   ST_HALT      | HLT retired; PC frozen until reset
module branch_pc_ctrl
   import cpu_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int OFF_W  = DEF_OFF_W
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_in,
   input  logic [2:0]        ex_flag_wr,
   input  logic [2:0]        ex_flags,
   input  logic              id_is_branch,
   input  logic              id_is_br_reg,
   input  logic [2:0]        id_cond,
   input  logic [OFF_W-1:0]  id_offset,
   input  logic [DATA_W-1:0] id_reg_target,
   input  logic [DATA_W-1:0] id_pc,
   input  logic              id_halt,
   output logic [DATA_W-1:0] pc_out,
   output logic [2:0]        flags_out,
   output logic              stall_out,
   output logic              flush,
   output logic              halted
);

   localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(2);

   pc_state_t         state_q, state_d;
   logic [DATA_W-1:0] pc_q, pc_d;
   logic [2:0]        flags_q, flags_d;
   logic              halted_q, halted_d;
   logic              stall_c, flush_c;
   logic              hazard, taken;
   logic [DATA_W-1:0] off_ext, target;

   branch_cond_eval u_cond_eval (
      .cond  (id_cond),
      .flags (flags_q),
      .taken (taken)
   );

   // Offset counts instruction words, so it is doubled before adding.
   assign off_ext = {{(DATA_W-OFF_W){id_offset[OFF_W-1]}}, id_offset};
   assign target  = id_is_br_reg ? id_reg_target
                                 : id_pc + PC_STEP + (off_ext << 1);

   assign hazard = id_is_branch && (id_cond != COND_UNC) &&
                   (ex_flag_wr != 3'b000) && (state_q == ST_RUN);

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      halted_d = halted_q;
      flags_d  = flags_q;
      stall_c  = 1'b0;
      flush_c  = 1'b0;
      if (!stall_in) begin
         flags_d = (flags_q & ~ex_flag_wr) | (ex_flags & ex_flag_wr);
         case (state_q)
            ST_HALT: ;
            default: begin
               if (hazard) begin
                  stall_c = 1'b1;
                  state_d = ST_FLAG_WAIT;
               end else begin
                  state_d = ST_RUN;
                  if (id_is_branch) begin
                     if (taken) begin
                        pc_d    = target;
                        flush_c = 1'b1;
                     end else begin
                        pc_d = pc_q + PC_STEP;
                     end
                  end else if (id_halt) begin
                     halted_d = 1'b1;
                     state_d  = ST_HALT;
                  end else begin
                     pc_d = pc_q + PC_STEP;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_RUN;
         pc_q     <= '0;
         flags_q  <= 3'b000;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         flags_q  <= flags_d;
         halted_q <= halted_d;
      end
   end

   assign pc_out    = pc_q;
   assign flags_out = flags_q;
   assign halted    = halted_q;
   assign stall_out = stall_c & ~rst;
   assign flush     = flush_c & ~rst;

endmodule

// File: tb/tb_branch_pc_ctrl.sv
// Scenario bench for branch_pc_ctrl: PC/flag expectations go through a queue
// checked one cycle later; stall_out/flush/halted are checked inline.
module tb_branch_pc_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_in;
   logic [2:0]  ex_flag_wr, ex_flags;
   logic        id_is_branch, id_is_br_reg;
   logic [2:0]  id_cond;
   logic [8:0]  id_offset;
   logic [15:0] id_reg_target, id_pc;
   logic        id_halt;
   logic [15:0] pc_out;
   logic [2:0]  flags_out;
   logic        stall_out, flush, halted;

   branch_pc_ctrl dut (
      .clk(clk), .rst(rst), .stall_in(stall_in),
      .ex_flag_wr(ex_flag_wr), .ex_flags(ex_flags),
      .id_is_branch(id_is_branch), .id_is_br_reg(id_is_br_reg),
      .id_cond(id_cond), .id_offset(id_offset),
      .id_reg_target(id_reg_target), .id_pc(id_pc), .id_halt(id_halt),
      .pc_out(pc_out), .flags_out(flags_out), .stall_out(stall_out),
      .flush(flush), .halted(halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [15:0] pc;
      logic [2:0]  flags;
   } exp_t;

   exp_t        exp_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [2:0]  ef;
   logic [15:0] cur_pc;

   // Scoreboard: one expectation per clock edge, checked just after the edge.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_tests++;
         if (pc_out !== e.pc || flags_out !== e.flags) begin
            n_fail++;
            $display("FAIL %s: pc_out=%h flags_out=%b, required pc=%h flags=%b",
                     e.name, pc_out, flags_out, e.pc, e.flags);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic exp_taken(input logic [2:0] c, input logic [2:0] f);
      logic n, z, v;
      n = f[2]; z = f[1]; v = f[0];
      case (c)
         3'd0: return ~z;
         3'd1: return z;
         3'd2: return ~z & ~n;
         3'd3: return n;
         3'd4: return z | ~n;
         3'd5: return n | z;
         3'd6: return v;
         default: return 1'b1;
      endcase
   endfunction

   task automatic clr();
      stall_in = 0; ex_flag_wr = 0; ex_flags = 0; id_is_branch = 0;
      id_is_br_reg = 0; id_cond = 0; id_offset = 0; id_reg_target = 0;
      id_pc = 0; id_halt = 0;
   endtask

   // Queue the expected post-edge PC and flags, then advance one clock.
   task automatic cyc(input string name, input logic [15:0] epc);
      exp_t e;
      if (!stall_in) ef = (ef & ~ex_flag_wr) | (ex_flags & ex_flag_wr);
      e.name = name; e.pc = epc; e.flags = ef;
      exp_q.push_back(e);
      cur_pc = epc;
      @(posedge clk); #2;
   endtask

   task automatic test_reset();
      clr(); rst = 1; ef = 0;
      id_is_branch = 1; id_cond = 3'b111; id_pc = 16'h0100;
      #3;
      n_tests++; if (pc_out !== 16'h0000 || flags_out !== 3'b000 || halted !== 1'b0) begin
         n_fail++; $display("FAIL reset_state: pc=%h flags=%b halted=%b required 0000/000/0", pc_out, flags_out, halted); end
      n_tests++; if (stall_out !== 1'b0 || flush !== 1'b0) begin
         n_fail++; $display("FAIL reset_comb: stall_out=%b flush=%b required 0/0", stall_out, flush); end
      clr();
      @(negedge clk); rst = 0;
      for (int i = 1; i <= 8; i++) begin
         if (i == 3) begin ex_flag_wr = 3'b111; ex_flags = 3'b101; end
         else begin ex_flag_wr = 0; ex_flags = 0; end
         cyc("run_inc", 16'(i * 2));
      end
      clr();
      #1 rst = 1;
      #1;
      n_tests++; if (pc_out !== 16'h0000 || flags_out !== 3'b000) begin
         n_fail++; $display("FAIL async_reset: pc=%h flags=%b required 0000/000", pc_out, flags_out); end
      ef = 0;
      @(negedge clk); rst = 0;
      cyc("post_rst_1", 16'h0002);
      cyc("post_rst_2", 16'h0004);
   endtask

   task automatic test_b_eq_taken();
      clr(); ex_flag_wr = 3'b010; ex_flags = 3'b010;
      cyc("set_z", cur_pc + 2);
      clr(); id_is_branch = 1; id_cond = 3'b001; id_pc = 16'h0004; id_offset = 9'd3;
      #1;
      n_tests++; if (flush !== 1'b1 || stall_out !== 1'b0) begin
         n_fail++; $display("FAIL b_eq_comb: flush=%b stall_out=%b required 1/0", flush, stall_out); end
      cyc("b_eq_taken", 16'h000C);
      clr();
   endtask

   task automatic test_flag_hazard();
      clr(); ex_flag_wr = 3'b010; ex_flags = 3'b000;
      cyc("clr_z", cur_pc + 2);
      // Hazard 1: Z becomes 1, NE not taken after the bubble.
      clr(); id_is_branch = 1; id_cond = 3'b000; id_pc = 16'h0100; id_offset = 9'd4;
      ex_flag_wr = 3'b010; ex_flags = 3'b010;
      #1;
      n_tests++; if (stall_out !== 1'b1 || flush !== 1'b0) begin
         n_fail++; $display("FAIL hz1_stall: stall_out=%b flush=%b required 1/0", stall_out, flush); end
      cyc("hz1_hold", cur_pc);
      ex_flag_wr = 0; ex_flags = 0;
      #1;
      n_tests++; if (stall_out !== 1'b0 || flush !== 1'b0) begin
         n_fail++; $display("FAIL hz1_resolve: stall_out=%b flush=%b required 0/0", stall_out, flush); end
      cyc("hz1_not_taken", cur_pc + 2);
      // Hazard 2: Z cleared, NE taken after the bubble.
      ex_flag_wr = 3'b010; ex_flags = 3'b000;
      #1;
      n_tests++; if (stall_out !== 1'b1) begin
         n_fail++; $display("FAIL hz2_stall: stall_out=%b required 1", stall_out); end
      cyc("hz2_hold", cur_pc);
      ex_flag_wr = 0;
      #1;
      n_tests++; if (stall_out !== 1'b0 || flush !== 1'b1) begin
         n_fail++; $display("FAIL hz2_resolve: stall_out=%b flush=%b required 0/1", stall_out, flush); end
      cyc("hz2_taken", 16'h010A);
      clr();
   endtask

   task automatic test_br_unc();
      clr(); id_is_branch = 1; id_is_br_reg = 1; id_cond = 3'b111;
      id_reg_target = 16'h1234; id_pc = 16'h0050; id_offset = 9'd5;
      ex_flag_wr = 3'b111; ex_flags = 3'b110;
      #1;
      n_tests++; if (stall_out !== 1'b0 || flush !== 1'b1) begin
         n_fail++; $display("FAIL br_unc_comb: stall_out=%b flush=%b required 0/1", stall_out, flush); end
      cyc("br_unc", 16'h1234);
      clr();
   endtask

   task automatic test_wrap();
      clr(); id_is_branch = 1; id_cond = 3'b111; id_pc = 16'hFFFE; id_offset = 9'd1;
      cyc("wrap_target", 16'h0002);
      id_pc = 16'h0000; id_offset = 9'h100;
      cyc("neg_offset", 16'hFE02);
      id_pc = 16'hFFF8; id_offset = 9'd2;
      cyc("to_fffe", 16'hFFFE);
      clr();
      cyc("inc_wrap", 16'h0000);
   endtask

   task automatic test_cond_table();
      logic [2:0] fset[5];
      logic       t;
      fset = '{3'b000, 3'b010, 3'b100, 3'b001, 3'b110};
      for (int k = 0; k < 5; k++) begin
         clr(); ex_flag_wr = 3'b111; ex_flags = fset[k];
         cyc("cond_setf", cur_pc + 2);
         for (int c = 0; c < 8; c++) begin
            clr(); id_is_branch = 1; id_cond = 3'(c); id_pc = 16'h0200; id_offset = 0;
            t = exp_taken(3'(c), fset[k]);
            #1;
            n_tests++; if (flush !== t) begin
               n_fail++; $display("FAIL cond%0d_f%b: flush=%b required %b", c, fset[k], flush, t); end
            cyc($sformatf("cond%0d_f%b_pc", c, fset[k]), t ? 16'h0202 : cur_pc + 2);
         end
      end
      clr();
   endtask

   task automatic test_stall_in();
      clr(); ex_flag_wr = 3'b010; ex_flags = 3'b000;
      cyc("sfw_clr_z", cur_pc + 2);
      clr(); id_is_branch = 1; id_cond = 3'b000; id_pc = 16'h0300; id_offset = 9'd1;
      ex_flag_wr = 3'b010; ex_flags = 3'b010;
      #1;
      n_tests++; if (stall_out !== 1'b1) begin
         n_fail++; $display("FAIL sfw_stall: stall_out=%b required 1", stall_out); end
      cyc("sfw_hold", cur_pc);
      stall_in = 1; ex_flag_wr = 3'b111; ex_flags = 3'b111;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_tests++; if (stall_out !== 1'b0 || flush !== 1'b0) begin
            n_fail++; $display("FAIL sfw_frozen_comb: stall_out=%b flush=%b required 0/0", stall_out, flush); end
         cyc("sfw_frozen", cur_pc);
      end
      // Still in FLAG_WAIT, so a live flag write must not re-stall.
      stall_in = 0; ex_flag_wr = 3'b001; ex_flags = 3'b001;
      #1;
      n_tests++; if (stall_out !== 1'b0 || flush !== 1'b0) begin
         n_fail++; $display("FAIL sfw_resolve: stall_out=%b flush=%b required 0/0", stall_out, flush); end
      cyc("sfw_resolve_pc", cur_pc + 2);
      clr(); stall_in = 1; id_is_branch = 1; id_cond = 3'b111; id_pc = 16'h0400;
      #1;
      n_tests++; if (flush !== 1'b0) begin
         n_fail++; $display("FAIL stall_redirect_held: flush=%b required 0", flush); end
      cyc("stall_redirect_hold", cur_pc);
      stall_in = 0;
      #1;
      n_tests++; if (flush !== 1'b1) begin
         n_fail++; $display("FAIL stall_redirect_release: flush=%b required 1", flush); end
      cyc("stall_redirect_pc", 16'h0402);
      clr();
   endtask

   task automatic test_halt();
      clr(); id_halt = 1;
      cyc("halt_enter", cur_pc);
      n_tests++; if (halted !== 1'b1) begin
         n_fail++; $display("FAIL halt_flag: halted=%b required 1", halted); end
      clr();
      for (int i = 0; i < 10; i++) begin
         id_is_branch = 1; id_cond = 3'b111; id_pc = 16'h0500;
         #1;
         n_tests++; if (flush !== 1'b0 || stall_out !== 1'b0 || halted !== 1'b1) begin
            n_fail++; $display("FAIL halt_frozen_comb: flush=%b stall_out=%b halted=%b required 0/0/1", flush, stall_out, halted); end
         cyc("halt_frozen", cur_pc);
      end
      clr(); rst = 1;
      #1;
      n_tests++; if (pc_out !== 16'h0000 || halted !== 1'b0) begin
         n_fail++; $display("FAIL halt_reset: pc=%h halted=%b required 0000/0", pc_out, halted); end
      ef = 0;
      @(negedge clk); rst = 0;
      cyc("halt_exit_run", 16'h0002);
   endtask

   initial begin
      clr(); rst = 1; ef = 0; cur_pc = 0;
      test_reset();
      test_b_eq_taken();
      test_flag_hazard();
      test_br_unc();
      test_wrap();
      test_cond_table();
      test_stall_in();
      test_halt();
      @(posedge clk); #3;
      n_tests++; if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size()); end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
